// File: rtl/demux_pkg.sv
// Shared constants and helpers for the 1:N stream demultiplexer.
// Optional feature macro: DEMUX_BROADCAST_EN (adds the Broadcast_In port).
package demux_pkg;

    // Largest supported channel count and default word width.
    localparam int DEMUX_MAX_CHANNELS  = 64;
    localparam int DEMUX_DEFAULT_WIDTH = 8;

    // Width of a channel select field: never narrower than one bit,
    // so a two-channel demux still has a usable select input.
    function automatic int sel_width(input int channels);
        if (channels <= 2) begin
            return 1;
        end
        return $clog2(channels);
    endfunction

endpackage

// File: rtl/demux_chan_slot.sv
// One-entry output register slot for a single demux channel.
// Holds one word for the consumer and reports whether it can take a new
// word this cycle (empty, or being popped right now).
module demux_chan_slot
    import demux_pkg::*;
#(
    parameter int DATA_WIDTH = DEMUX_DEFAULT_WIDTH
) (
    input  logic                  Clock_In,
    input  logic                  Reset_In,
    input  logic                  Load_In,
    input  logic [DATA_WIDTH-1:0] Data_In,
    output logic                  Valid_Out,
    input  logic                  Ready_In,
    output logic [DATA_WIDTH-1:0] Data_Out,
    output logic                  Can_Accept_Out
);

    // Handshake: a word moves out when Valid_Out && Ready_In are both high on
    // a rising edge; once Valid_Out is raised it stays high and Data_Out stays
    // stable until that pop happens.
    assign Can_Accept_Out = !Valid_Out || Ready_In;

    // Slot state: load wins over pop so drain-and-refill happens in one cycle.
    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            Valid_Out <= 1'b0;
            Data_Out  <= '0;
        end else if (Load_In) begin
            Valid_Out <= 1'b1;
            Data_Out  <= Data_In;
        end else if (Ready_In) begin
            // Data_Out keeps its last value; consumers qualify with valid.
            Valid_Out <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_1_n_stream.sv
// Registered, handshaked 1:N stream demultiplexer.
// A word on the single input stream is routed to the channel named by
// Select_In and parked in that channel's one-entry slot. An out-of-range
// select is accepted and dropped, raising a sticky error flag.
// Optional feature macro: DEMUX_BROADCAST_EN adds Broadcast_In, which loads
// the input word into every slot at once.
module demux_1_n_stream
    import demux_pkg::*;
#(
    parameter  int DATA_WIDTH = DEMUX_DEFAULT_WIDTH,
    parameter  int CHANNELS   = 4,
    localparam int SEL_WIDTH  = sel_width(CHANNELS)
) (
    input  logic                           Clock_In,
    input  logic                           Reset_In,
    input  logic                           Enable_In,
    input  logic                           Valid_In,
    output logic                           Ready_Out,
    input  logic [DATA_WIDTH-1:0]          Data_In,
    input  logic [SEL_WIDTH-1:0]           Select_In,
    output logic [CHANNELS-1:0]            Valid_Out,
    input  logic [CHANNELS-1:0]            Ready_In,
    output logic [CHANNELS*DATA_WIDTH-1:0] Data_Out,
    output logic                           Sel_Error_Out
`ifdef DEMUX_BROADCAST_EN
    ,
    input  logic                           Broadcast_In
`endif
);

    // Input handshake: a word is transferred on a rising edge where
    // Valid_In && Ready_Out. Ready_Out never depends on Valid_In, so the
    // producer may wait for ready before raising valid without deadlock.

    logic [CHANNELS-1:0] sel_onehot;
    logic [CHANNELS-1:0] can_accept;
    logic [CHANNELS-1:0] load;
    logic                sel_illegal;
    logic                broadcast;
    logic                transfer;

`ifdef DEMUX_BROADCAST_EN
    assign broadcast = Broadcast_In;
`else
    assign broadcast = 1'b0;
`endif

    // Select decode; when CHANNELS fills the select range every code is legal.
    generate
        if ((2 ** SEL_WIDTH) > CHANNELS) begin : g_sel_check
            assign sel_illegal = (Select_In >= SEL_WIDTH'(CHANNELS));
        end else begin : g_sel_full
            assign sel_illegal = 1'b0;
        end
    endgenerate

    for (genvar k = 0; k < CHANNELS; k++) begin : g_decode
        assign sel_onehot[k] = (Select_In == SEL_WIDTH'(k));
    end

    // Ready for the current request: broadcast needs every slot free, a legal
    // unicast needs only its own slot, an illegal select is always swallowed.
    always_comb begin
        Ready_Out = 1'b0;
        if (Enable_In) begin
            if (broadcast) begin
                Ready_Out = &can_accept;
            end else if (sel_illegal) begin
                Ready_Out = 1'b1;
            end else begin
                Ready_Out = |(can_accept & sel_onehot);
            end
        end
    end

    assign transfer = Valid_In && Ready_Out;

    // Per-slot load strobe; an illegal unicast select matches no slot.
    always_comb begin
        load = '0;
        if (transfer) begin
            load = broadcast ? {CHANNELS{1'b1}} : sel_onehot;
        end
    end

    // Sticky select error, cleared only by reset; broadcasts never set it.
    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            Sel_Error_Out <= 1'b0;
        end else if (transfer && !broadcast && sel_illegal) begin
            Sel_Error_Out <= 1'b1;
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_slot
        demux_chan_slot #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_slot (
            .Clock_In      (Clock_In),
            .Reset_In      (Reset_In),
            .Load_In       (load[k]),
            .Data_In       (Data_In),
            .Valid_Out     (Valid_Out[k]),
            .Ready_In      (Ready_In[k]),
            .Data_Out      (Data_Out[k*DATA_WIDTH +: DATA_WIDTH]),
            .Can_Accept_Out(can_accept[k])
        );
    end

endmodule

// File: tb/tb_demux_1_n_stream.sv
// Directed self-checking bench for demux_1_n_stream.
// dut_a: 4 channels (routing, backpressure, enable, reset, broadcast).
// dut_b: 3 channels (illegal select and sticky error).
module tb_demux_1_n_stream;

    logic clk = 1'b0;
    logic rst;

    // dut_a stimulus / observation
    logic        en_a, valid_a;
    logic [7:0]  data_a;
    logic [1:0]  sel_a;
    logic [3:0]  ready_in_a;
    logic        ready_out_a;
    logic [3:0]  valid_out_a;
    logic [31:0] data_out_a;
    logic        err_a;
    logic        bcast_a;

    // dut_b stimulus / observation
    logic        en_b, valid_b;
    logic [7:0]  data_b;
    logic [1:0]  sel_b;
    logic [2:0]  ready_in_b;
    logic        ready_out_b;
    logic [2:0]  valid_out_b;
    logic [23:0] data_out_b;
    logic        err_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    demux_1_n_stream #(.DATA_WIDTH(8), .CHANNELS(4)) dut_a (
        .Clock_In     (clk),
        .Reset_In     (rst),
        .Enable_In    (en_a),
        .Valid_In     (valid_a),
        .Ready_Out    (ready_out_a),
        .Data_In      (data_a),
        .Select_In    (sel_a),
        .Valid_Out    (valid_out_a),
        .Ready_In     (ready_in_a),
        .Data_Out     (data_out_a),
        .Sel_Error_Out(err_a)
`ifdef DEMUX_BROADCAST_EN
        ,
        .Broadcast_In (bcast_a)
`endif
    );

    demux_1_n_stream #(.DATA_WIDTH(8), .CHANNELS(3)) dut_b (
        .Clock_In     (clk),
        .Reset_In     (rst),
        .Enable_In    (en_b),
        .Valid_In     (valid_b),
        .Ready_Out    (ready_out_b),
        .Data_In      (data_b),
        .Select_In    (sel_b),
        .Valid_Out    (valid_out_b),
        .Ready_In     (ready_in_b),
        .Data_Out     (data_out_b),
        .Sel_Error_Out(err_b)
`ifdef DEMUX_BROADCAST_EN
        ,
        .Broadcast_In (1'b0)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change and outputs
    // are sampled here, away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push one word into dut_a with a free slot, leaving valid low afterwards.
    task automatic send_a(input logic [1:0] sel, input logic [7:0] data);
        valid_a = 1'b1;
        sel_a   = sel;
        data_a  = data;
        #1;
        check("send_a_ready", ready_out_a, 1'b1);
        tick();
        valid_a = 1'b0;
    endtask

    initial begin
        bcast_a    = 1'b0;
        rst        = 1'b1;
        en_a       = 1'b1;
        valid_a    = 1'b1;
        data_a     = 8'hFF;
        sel_a      = 2'd0;
        ready_in_a = 4'b1111;
        en_b       = 1'b1;
        valid_b    = 1'b1;
        data_b     = 8'hEE;
        sel_b      = 2'd3;
        ready_in_b = 3'b111;

        // 1: reset held two cycles with valid high
        tick();
        tick();
        check("rst_valid_a", valid_out_a, 4'b0000);
        check("rst_data_a", data_out_a, 32'h0);
        check("rst_err_a", err_a, 1'b0);
        check("rst_valid_b", valid_out_b, 3'b000);
        check("rst_err_b", err_b, 1'b0);
        rst     = 1'b0;
        valid_a = 1'b0;
        valid_b = 1'b0;

        // 2: routing 0xA5 to channel 2
        tick();
        send_a(2'd2, 8'hA5);
        check("route_valid", valid_out_a, 4'b0100);
        check("route_data", data_out_a[23:16], 8'hA5);
        tick();
        check("route_drained", valid_out_a, 4'b0000);

        // 3: backpressure on channel 1, channel 3 keeps flowing
        ready_in_a = 4'b1101;
        send_a(2'd1, 8'h11);
        check("bp_first_valid", valid_out_a, 4'b0010);
        check("bp_first_data", data_out_a[15:8], 8'h11);
        valid_a = 1'b1;
        sel_a   = 2'd1;
        data_a  = 8'h22;
        #1;
        check("bp_second_stalled", ready_out_a, 1'b0);
        send_a(2'd3, 8'h33);
        check("bp_ch3_valid", valid_out_a, 4'b1010);
        check("bp_ch3_data", data_out_a[31:24], 8'h33);
        check("bp_ch1_held", data_out_a[15:8], 8'h11);
        valid_a = 1'b1;
        sel_a   = 2'd1;
        data_a  = 8'h22;
        tick();
        check("bp_stall_valid", valid_out_a, 4'b0010);
        check("bp_stall_data", data_out_a[15:8], 8'h11);
        check("bp_stall_ready", ready_out_a, 1'b0);
        ready_in_a = 4'b1111;
        #1;
        check("bp_pop_ready", ready_out_a, 1'b1);
        tick();
        valid_a = 1'b0;
        check("bp_refill_valid", valid_out_a, 4'b0010);
        check("bp_refill_data", data_out_a[15:8], 8'h22);
        tick();
        check("bp_final_drain", valid_out_a, 4'b0000);

        // 4: illegal select on the 3-channel instance
        valid_b = 1'b1;
        sel_b   = 2'd3;
        data_b  = 8'h5A;
        #1;
        check("ill_ready", ready_out_b, 1'b1);
        tick();
        valid_b = 1'b0;
        check("ill_no_valid", valid_out_b, 3'b000);
        check("ill_err_set", err_b, 1'b1);
        check("ill_err_a_clear", err_a, 1'b0);
        valid_b = 1'b1;
        sel_b   = 2'd0;
        data_b  = 8'hC3;
        tick();
        valid_b = 1'b0;
        check("ill_legal_after", valid_out_b, 3'b001);
        check("ill_legal_data", data_out_b[7:0], 8'hC3);
        tick();
        tick();
        check("ill_err_sticky", err_b, 1'b1);

        // 5: enable low still drains, then reset mid-operation
        ready_in_a = 4'b0000;
        send_a(2'd0, 8'h01);
        send_a(2'd1, 8'h02);
        send_a(2'd3, 8'h04);
        check("en_filled", valid_out_a, 4'b1011);
        en_a    = 1'b0;
        valid_a = 1'b1;
        sel_a   = 2'd2;
        data_a  = 8'h99;
        #1;
        check("en_off_ready", ready_out_a, 1'b0);
        ready_in_a = 4'b1111;
        #1;
        check("en_off_ready_drain", ready_out_a, 1'b0);
        tick();
        check("en_off_drained", valid_out_a, 4'b0000);
        check("en_off_ch2_kept", data_out_a[23:16], 8'hA5);
        valid_a    = 1'b0;
        en_a       = 1'b1;
        ready_in_a = 4'b0000;
        send_a(2'd0, 8'h81);
        send_a(2'd1, 8'h82);
        send_a(2'd3, 8'h84);
        check("rst_mid_before", valid_out_a, 4'b1011);
        rst     = 1'b1;
        valid_a = 1'b1;
        tick();
        check("rst_mid_valid", valid_out_a, 4'b0000);
        check("rst_mid_data", data_out_a, 32'h0);
        check("rst_mid_err_b", err_b, 1'b0);
        rst     = 1'b0;
        valid_a = 1'b0;
        tick();

`ifdef DEMUX_BROADCAST_EN
        // 6: broadcast waits for every slot to be able to accept
        ready_in_a = 4'b1110;
        send_a(2'd0, 8'h77);
        bcast_a = 1'b1;
        valid_a = 1'b1;
        sel_a   = 2'd3;
        data_a  = 8'h3C;
        #1;
        check("bc_stalled", ready_out_a, 1'b0);
        tick();
        check("bc_stall_data", data_out_a[7:0], 8'h77);
        ready_in_a = 4'b1111;
        #1;
        check("bc_ready", ready_out_a, 1'b1);
        tick();
        valid_a = 1'b0;
        bcast_a = 1'b0;
        check("bc_valid", valid_out_a, 4'b1111);
        check("bc_data", data_out_a, 32'h3C3C3C3C);
        check("bc_no_err", err_a, 1'b0);
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
